exception_ctrl: RTL

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

---
 rtl/exception_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/exception_ctrl.sv
// exception_ctrl
//   Commits exceptions and interrupts from the MEM stage to CP0 and
//   redirects the pipeline.
//
//   An instruction in MEM is "accepted" when the controller is IDLE and
//   either an interrupt is pending or the instruction carries one of the
//   codes 8 (syscall), a (invalid inst), c (overflow), d (trap), e (eret).
//   A pending interrupt always wins and commits code 1.
//
//   Accept cycle : excepttype_o = code (one-cycle pulse), flush_o = 1 and
//                  new_pc_o = target (EPC for eret, EXC_VECTOR otherwise).
//   FLUSH        : flush_o held for the remaining FLUSH_CYCLES-1 cycles.
//   RESUME       : one quiet cycle (no flush, no stall), then back to IDLE.
//   The target PC is registered at accept and held until IDLE, so later
//   changes to cp0_epc_i cannot disturb the redirect.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   excepttype_i [31:0]      exception code from MEM
//   mem_valid_i              MEM holds a real instruction
//   cp0_status_i/cause_i/epc_i [31:0]  forwarded CP0 registers
//   stallreq_id_i/ex_i       stall requests from decode / execute
//   excepttype_o [31:0]      code committed to CP0 (0 = none)
//   flush_o                  pipeline flush
//   new_pc_o [31:0]          redirect target
//   stall_o [5:0]            stall vector {WB,MEM,EX,ID,IF,PC}
//   busy_o                   registered: state is FLUSH or RESUME
//   state_o [1:0]            current FSM state (0 IDLE, 1 FLUSH, 2 RESUME)

module exception_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] excepttype_i,
  input  logic        mem_valid_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  output logic [31:0] excepttype_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [5:0]  stall_o,
  output logic        busy_o,
  output logic [1:0]  state_o
);

  // Number of FLUSH-state cycles that follow the accept cycle.
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_RESUME = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic        busy_q;

  logic        irq_pending;
  logic        code_listed;
  logic        accept;
  logic [31:0] accept_code;
  logic [31:0] accept_pc;

  // Interrupt: some unmasked line raised, IE=1, EXL=0.
  assign irq_pending = (|(cp0_cause_i[15:8] & cp0_status_i[15:8])) &&
                       cp0_status_i[0] && !cp0_status_i[1];

  always_comb begin
    code_listed = 1'b0;
    case (excepttype_i)
      32'h8, 32'ha, 32'hc, 32'hd, 32'he: code_listed = 1'b1;
      default:                           code_listed = 1'b0;
    endcase
  end

  // Gated by rst so nothing is committed while reset is held.
  assign accept = rst && (state_q == ST_IDLE) && mem_valid_i &&
                  (irq_pending || code_listed);

  assign accept_code = irq_pending ? 32'h1 : excepttype_i;
  assign accept_pc   = (!irq_pending && excepttype_i == 32'he) ? cp0_epc_i
                                                               : EXC_VECTOR;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_d         = pc_q;
    excepttype_o = 32'h0;
    flush_o      = 1'b0;
    new_pc_o     = 32'h0;
    stall_o      = 6'b000000;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          excepttype_o = accept_code;
          flush_o      = 1'b1;
          new_pc_o     = accept_pc;
          pc_d         = accept_pc;
          cnt_d        = FLUSH_LOAD;
          state_d      = (FLUSH_LOAD == 4'd0) ? ST_RESUME : ST_FLUSH;
        end else if (stallreq_ex_i) begin
          stall_o = 6'b001111;
        end else if (stallreq_id_i) begin
          stall_o = 6'b000111;
        end
      end
      ST_FLUSH: begin
        flush_o  = 1'b1;
        new_pc_o = pc_q;
        // Leave once the countdown reaches zero.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_RESUME;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESUME: begin
        new_pc_o = pc_q;
        pc_d     = 32'h0;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are forced quiet while reset is asserted, independent of clk.
    if (!rst) begin
      excepttype_o = 32'h0;
      flush_o      = 1'b0;
      new_pc_o     = 32'h0;
      stall_o      = 6'b000000;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      pc_q    <= 32'h0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign busy_o  = busy_q;
  assign state_o = state_q;

endmodule
